fb_dbuf_clear: RTL and testbench

- Parametrised, double-buffered successor of the single-page framebuffer RAM.
- Two pages live in one dual-port block RAM. The display scan reads the front page; the drawing logic writes the back page.
- A page swap is requested at any time but takes effect only at a frame boundary, so no frame shows a torn image.
- A built-in clear engine fills the back page with a constant, one word per clock, so the host need not clear it itself.

---
 rtl/fb_pkg.sv | 12 +
 rtl/fb_dbuf_clear_if.sv | 33 +++
 rtl/fb_dp_ram.sv | 30 +++
 rtl/fb_dbuf_clear.sv | 94 +++++++++
 tb/tb_fb_dbuf_clear.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the double-buffered framebuffer with clear engine.
package fb_pkg;

  localparam int FB_DATA_W = 6;
  localparam int FB_ADDR_W = 11;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/fb_dbuf_clear_if.sv
// Host/display bundle for fb_dbuf_clear; master = drawing/scan side, slave = framebuffer.
interface fb_dbuf_clear_if #(
  parameter int DATA_W = fb_pkg::FB_DATA_W,
  parameter int ADDR_W = fb_pkg::FB_ADDR_W
);
  import fb_pkg::*;

  // No ready/valid pairs: wr_en is accepted only while busy=0, otherwise dropped;
  // swap_req/clear_req/frame_start are single-cycle pulses; swap_done pulses once per swap.
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              frame_start;
  logic              swap_req;
  logic              clear_req;
  logic              front_page;
  logic              swap_done;
  logic              busy;
  clr_state_e        state_dbg;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, frame_start, swap_req, clear_req,
    input  rd_data, front_page, swap_done, busy, state_dbg
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, frame_start, swap_req, clear_req,
    output rd_data, front_page, swap_done, busy, state_dbg
  );

endinterface

// File: rtl/fb_dp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module fb_dp_ram #(
  parameter int DATA_W = 6,
  parameter int AW     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem [2**AW];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem[waddr_i] <= wdata_i;
   end

   // Output register reset maps onto the block RAM output latch reset.
   always_ff @(posedge clk) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= mem[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/fb_dbuf_clear.sv
// Two-page framebuffer: front page scanned out, back page drawn or cleared,
// page swaps deferred to the next frame boundary.
module fb_dbuf_clear
  import fb_pkg::*;
#(
  parameter int                 DATA_W    = FB_DATA_W,
  parameter int                 ADDR_W    = FB_ADDR_W,
  parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
  input logic            clk,
  input logic            rst,
  fb_dbuf_clear_if.slave bus
);

   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic              front_q, front_d;
   logic              pend_q, pend_d;
   logic              done_q;
   logic              busy;
   logic              swap_go;

   logic              ram_we;
   logic [ADDR_W:0]   ram_waddr;
   logic [DATA_W-1:0] ram_wdata;
   logic [ADDR_W:0]   ram_raddr;

   assign busy    = (state_q == ST_CLEAR);
   assign swap_go = bus.frame_start && !busy && (pend_q || bus.swap_req);

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      front_d   = swap_go ? ~front_q : front_q;
      pend_d    = swap_go ? 1'b0 : (pend_q | bus.swap_req);
      case (state_q)
         ST_IDLE: begin
            if (bus.clear_req) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = '0;
            end
         end
         ST_CLEAR: begin
            // Terminal compare ends the sweep; the counter is never used past it.
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == {ADDR_W{1'b1}}) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         clr_cnt_q <= '0;
         front_q   <= 1'b0;
         pend_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         front_q   <= front_d;
         pend_q    <= pend_d;
         done_q    <= swap_go;
      end
   end

   // Clear engine owns the write port while running; reset suppresses the in-flight write.
   always_comb begin
      ram_we    = !rst && (busy || bus.wr_en);
      ram_waddr = {~front_q, (busy ? clr_cnt_q : bus.wr_addr)};
      ram_wdata = busy ? CLEAR_VAL : bus.wr_data;
      ram_raddr = {front_q, bus.rd_addr};
   end

   fb_dp_ram #(
      .DATA_W (DATA_W),
      .AW     (ADDR_W + 1)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .raddr_i (ram_raddr),
      .rdata_o (bus.rd_data)
   );

   assign bus.front_page = front_q;
   assign bus.swap_done  = done_q;
   assign bus.busy       = busy;
   assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_fb_dbuf_clear.sv
// Directed bench for fb_dbuf_clear: page swaps, host writes, clear engine, reset abort.
module tb_fb_dbuf_clear;
  import fb_pkg::*;

  localparam int DW    = 6;
  localparam int AW    = 11;
  localparam int DEPTH = 2**AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  fb_dbuf_clear_if bus ();

  fb_dbuf_clear dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
    bus.rd_addr = a;
    tick();
    d = bus.rd_data;
  endtask

  task automatic do_swap(input logic exp_front);
    bus.swap_req    = 1'b1;
    bus.frame_start = 1'b1;
    tick();
    bus.swap_req    = 1'b0;
    bus.frame_start = 1'b0;
    chk("swap_front", bus.front_page, exp_front);
    chk("swap_done_hi", bus.swap_done, 1'b1);
    tick();
    chk("swap_done_lo", bus.swap_done, 1'b0);
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 5000) begin
      n++;
      tick();
    end
  endtask

  task automatic fill_back(input logic [DW-1:0] d);
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(i);
      bus.wr_data = d;
      tick();
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic read_all_zero(input string name);
    logic [DW-1:0] d;
    int errs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      rd(AW'(i), d);
      if (d !== '0) errs++;
    end
    chk(name, errs, 0);
  endtask

  // ---------------- vector table / scoreboard ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t          tbl [6];
  logic [DW-1:0] exp_q [$];

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] e;
    int            n;
    logic          stayed;

    tbl[0] = '{addr: 11'd0,    data: 6'h01, exp: 6'h01};
    tbl[1] = '{addr: 11'd1,    data: 6'h3F, exp: 6'h3F};
    tbl[2] = '{addr: 11'd5,    data: 6'h15, exp: 6'h15};
    tbl[3] = '{addr: 11'd1024, data: 6'h2A, exp: 6'h2A};
    tbl[4] = '{addr: 11'd2046, data: 6'h00, exp: 6'h00};
    tbl[5] = '{addr: 11'd2047, data: 6'h33, exp: 6'h33};

    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
    bus.frame_start = 1'b0; bus.swap_req = 1'b0; bus.clear_req = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_front", bus.front_page, 1'b0);
    chk("rst_rd_data", bus.rd_data, '0);
    chk("rst_swap_done", bus.swap_done, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_state", bus.state_dbg, ST_IDLE);

    // Basic write, deferred swap, read back
    wr(11'd5, 6'h2A);
    bus.swap_req = 1'b1; tick(); bus.swap_req = 1'b0;
    chk("basic_no_swap_yet", bus.front_page, 1'b0);
    bus.frame_start = 1'b1; tick(); bus.frame_start = 1'b0;
    chk("basic_front", bus.front_page, 1'b1);
    chk("basic_swap_done", bus.swap_done, 1'b1);
    tick();
    chk("basic_swap_done_lo", bus.swap_done, 1'b0);
    rd(11'd5, d);
    chk("basic_rd", d, 6'h2A);

    // Table vectors: write back page 0, display unaffected, then swap and read
    foreach (tbl[i]) begin
      wr(tbl[i].addr, tbl[i].data);
      exp_q.push_back(tbl[i].exp);
    end
    rd(11'd5, d);
    chk("front_untouched", d, 6'h2A);
    do_swap(1'b0);
    foreach (tbl[i]) begin
      rd(tbl[i].addr, d);
      e = exp_q.pop_front();
      chk($sformatf("tbl_rd_%0d", i), d, e);
    end

    // Deferred swap with repeated requests
    stayed = 1'b1;
    for (int c = 0; c < 40; c++) begin
      bus.swap_req = (c == 0 || c == 10 || c == 20);
      tick();
      if (bus.front_page !== 1'b0 || bus.swap_done !== 1'b0) stayed = 1'b0;
    end
    bus.swap_req = 1'b0;
    chk("defer_held", stayed, 1'b1);
    bus.frame_start = 1'b1; tick(); bus.frame_start = 1'b0;
    chk("defer_front", bus.front_page, 1'b1);
    chk("defer_done", bus.swap_done, 1'b1);
    tick();
    bus.frame_start = 1'b1; tick(); bus.frame_start = 1'b0;
    chk("defer_single_toggle", bus.front_page, 1'b1);
    chk("defer_no_extra_done", bus.swap_done, 1'b0);

    // Full clear with dropped write, ignored clear_req, blocked swap
    fill_back(6'h3F);
    bus.clear_req = 1'b1; tick(); bus.clear_req = 1'b0;
    chk("clr_state", bus.state_dbg, ST_CLEAR);
    n = 0;
    while (bus.busy === 1'b1 && n < 5000) begin
      bus.wr_en       = (n == 10);
      bus.wr_addr     = 11'd100;
      bus.wr_data     = 6'h15;
      bus.clear_req   = (n == 20);
      bus.swap_req    = (n == 30);
      bus.frame_start = (n == 40);
      n++;
      tick();
    end
    bus.wr_en = 1'b0; bus.clear_req = 1'b0; bus.swap_req = 1'b0; bus.frame_start = 1'b0;
    chk("clr_busy_cycles", n, DEPTH);
    chk("clr_blocked_swap", bus.front_page, 1'b1);
    bus.frame_start = 1'b1; tick(); bus.frame_start = 1'b0;
    chk("clr_pend_swap", bus.front_page, 1'b0);
    chk("clr_pend_done", bus.swap_done, 1'b1);
    read_all_zero("clr_all_zero");
    wr(11'd100, 6'h15);
    do_swap(1'b1);
    rd(11'd100, d);
    chk("post_clr_write", d, 6'h15);

    // Simultaneous swap + clear: clear targets the page just left
    wr(11'd7, 6'h11);
    bus.clear_req = 1'b1; bus.swap_req = 1'b1; bus.frame_start = 1'b1;
    tick();
    bus.clear_req = 1'b0; bus.swap_req = 1'b0; bus.frame_start = 1'b0;
    chk("sim_front", bus.front_page, 1'b0);
    chk("sim_done", bus.swap_done, 1'b1);
    chk("sim_busy", bus.busy, 1'b1);
    wait_busy(n);
    chk("sim_busy_cycles", n, DEPTH);
    rd(11'd7, d);
    chk("sim_new_front_kept", d, 6'h11);
    do_swap(1'b1);
    rd(11'd5, d);
    chk("sim_old_page_clr5", d, 6'h00);
    rd(11'd100, d);
    chk("sim_old_page_clr100", d, 6'h00);

    // Reset at clear cycle 300
    wr(11'd0, 6'h3F); wr(11'd299, 6'h3F); wr(11'd300, 6'h3F); wr(11'd2047, 6'h3F);
    bus.clear_req = 1'b1; tick(); bus.clear_req = 1'b0;
    for (int c = 0; c < 300; c++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_busy", bus.busy, 1'b0);
    chk("rst_mid_front", bus.front_page, 1'b0);
    chk("rst_mid_done", bus.swap_done, 1'b0);
    chk("rst_mid_state", bus.state_dbg, ST_IDLE);
    rd(11'd0, d);
    chk("rst_mid_a0", d, 6'h00);
    rd(11'd299, d);
    chk("rst_mid_a299", d, 6'h00);
    rd(11'd300, d);
    chk("rst_mid_a300", d, 6'h3F);
    rd(11'd2047, d);
    chk("rst_mid_a2047", d, 6'h3F);
    wr(11'd0, 6'h2A);
    bus.clear_req = 1'b1; tick(); bus.clear_req = 1'b0;
    wait_busy(n);
    chk("restart_busy_cycles", n, DEPTH);
    do_swap(1'b1);
    rd(11'd0, d);
    chk("restart_a0", d, 6'h00);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
